// File: rtl/pcie_tx_pkg.sv
// ============================================================================
//  Module   : pcie_tx_pkg
//  Brief    : Shared types and constants for the Tx source mux scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pcie_tx_pkg;

    typedef enum logic [1:0] {
        OS_MODE = 2'b00,
        DATA    = 2'b01,
        SKP     = 2'b10
    } tx_state_e;

    localparam logic SEL_DATA = 1'b1;
    localparam logic SEL_OS   = 1'b0;

    localparam int DEFAULT_SKP_INTERVAL = 370;
    localparam int DEFAULT_CNT_W        = 16;

    // An idle data source is always at a packet boundary.
    function automatic logic at_boundary(input logic req,
                                         input logic ready,
                                         input logic boundary);
        return (req & ready & boundary) | ~req;
    endfunction

endpackage : pcie_tx_pkg

`default_nettype wire

// File: rtl/tx_mux_scheduler_if.sv
// ============================================================================
//  Module   : tx_mux_scheduler_if
//  Brief    : Control bundle between LTSSM/LPIF/OS generator and the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tx_mux_scheduler_if #(
    parameter int CNT_W = 16
);

    logic             link_l0;
    logic             data_req;
    logic             data_boundary;
    logic             os_done;
    logic             sel;
    logic             data_ready;
    logic             skp_start;
    logic             skp_pending;
    logic [CNT_W-1:0] skp_count;

    // Scheduler side
    modport slave (
        input  link_l0,
        input  data_req,
        input  data_boundary,
        input  os_done,
        output sel,
        output data_ready,
        output skp_start,
        output skp_pending,
        output skp_count
    );

    // Environment side (LTSSM, LPIF source, OS generator, mux)
    modport master (
        output link_l0,
        output data_req,
        output data_boundary,
        output os_done,
        input  sel,
        input  data_ready,
        input  skp_start,
        input  skp_pending,
        input  skp_count
    );

endinterface : tx_mux_scheduler_if

`default_nettype wire

// File: rtl/tx_mux_scheduler_skp_interval_timer.sv
// ============================================================================
//  Module   : skp_interval_timer
//  Brief    : Saturating data-mode cycle counter raising skp_pending.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module skp_interval_timer #(
    parameter int SKP_INTERVAL = 370,
    parameter int CNT_W        = 16
) (
    input  wire  clk,
    input  wire  reset,
    input  logic count_en,
    input  logic skp_take,
    output logic skp_pending
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (skp_take) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (count_en) begin
            // Saturate at the last count so a long packet cannot wrap the interval.
            if (cnt_q == LAST_CNT) begin
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign skp_pending = pending_q;

endmodule : skp_interval_timer

`default_nettype wire

// File: rtl/tx_mux_scheduler.sv
// ============================================================================
//  Module   : tx_mux_scheduler
//  Brief    : Sequences the Tx source mux between OS generator and LPIF data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_mux_scheduler
    import pcie_tx_pkg::*;
#(
    parameter int SKP_INTERVAL = DEFAULT_SKP_INTERVAL,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  wire                clk,
    input  wire                reset,
    tx_mux_scheduler_if.slave  bus
);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic             sel_q;
    logic             sel_d;
    logic             data_ready_q;
    logic             data_ready_d;
    logic             skp_start_q;
    logic             skp_start_d;
    logic [CNT_W-1:0] skp_count_q;
    logic [CNT_W-1:0] skp_count_d;

    logic             w_bnd;
    logic             w_skp_take;
    logic             w_skp_pending;

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_interval_timer (
        .clk         (clk),
        .reset       (reset),
        .count_en    (state_q == DATA),
        .skp_take    (w_skp_take),
        .skp_pending (w_skp_pending)
    );

    always_comb begin
        w_bnd   = at_boundary(bus.data_req, data_ready_q, bus.data_boundary);
        state_d = state_q;
        case (state_q)
            OS_MODE: begin
                if (bus.link_l0 && bus.os_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Link loss outranks a pending SKP at the same boundary.
                if (w_bnd) begin
                    if (!bus.link_l0) begin
                        state_d = OS_MODE;
                    end else if (w_skp_pending) begin
                        state_d = SKP;
                    end
                end
            end
            SKP: begin
                if (bus.os_done) begin
                    state_d = bus.link_l0 ? DATA : OS_MODE;
                end
            end
            default: state_d = OS_MODE;
        endcase

        w_skp_take   = (state_q == DATA) && (state_d == SKP);
        // Outputs follow the next state so sel and data_ready drop on the same edge.
        sel_d        = (state_d == DATA) ? SEL_DATA : SEL_OS;
        data_ready_d = (state_d == DATA);
        skp_start_d  = w_skp_take;
        skp_count_d  = skp_count_q + CNT_W'(w_skp_take);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OS_MODE;
            sel_q        <= SEL_OS;
            data_ready_q <= 1'b0;
            skp_start_q  <= 1'b0;
            skp_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_ready_q <= data_ready_d;
            skp_start_q  <= skp_start_d;
            skp_count_q  <= skp_count_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.skp_start   = skp_start_q;
    assign bus.skp_pending = w_skp_pending;
    assign bus.skp_count   = skp_count_q;

endmodule : tx_mux_scheduler

`default_nettype wire

// File: tb/tb_tx_mux_scheduler.sv
// ============================================================================
//  Module   : tb_tx_mux_scheduler
//  Brief    : Directed self-checking bench for tx_mux_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tx_mux_scheduler;
    import pcie_tx_pkg::*;

    localparam int SKP_INTERVAL = 8;
    localparam int CNT_W        = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tx_mux_scheduler_if #(.CNT_W(CNT_W)) bus ();

    tx_mux_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        bus.link_l0       = 1'b0;
        bus.os_done       = 1'b0;
        bus.data_req      = 1'b0;
        bus.data_boundary = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic enter_data();
        bus.link_l0 = 1'b1;
        bus.os_done = 1'b1;
        tick();
        bus.os_done = 1'b0;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.link_l0       = 1'b1;
        bus.os_done       = 1'b1;
        bus.data_req      = 1'b0;
        bus.data_boundary = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.sel, bus.data_ready, bus.skp_start, bus.skp_pending, bus.skp_count} !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got sel=%b rdy=%b start=%b pend=%b cnt=%0d, want all 0",
                         i, bus.sel, bus.data_ready, bus.skp_start, bus.skp_pending, bus.skp_count);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.sel !== 1'b1 || bus.data_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got sel=%b rdy=%b, want 1 1", bus.sel, bus.data_ready);
        end
        bus.os_done = 1'b0;
    endtask

    task automatic test_link_up();
        do_reset();
        bus.link_l0 = 1'b0;
        bus.os_done = 1'b1;
        tick();
        checks++;
        if (bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL os_done_no_link: got sel=%b, want 0", bus.sel);
        end
        bus.os_done = 1'b0;
        bus.link_l0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.sel !== 1'b0 || bus.data_ready !== 1'b0) begin
                failures++;
                $display("FAIL link_up_wait cyc%0d: got sel=%b rdy=%b, want 0 0", i, bus.sel, bus.data_ready);
            end
        end
        bus.os_done = 1'b1;
        tick();
        bus.os_done = 1'b0;
        checks++;
        if (bus.sel !== 1'b1 || bus.data_ready !== 1'b1) begin
            failures++;
            $display("FAIL link_up_enter: got sel=%b rdy=%b, want 1 1", bus.sel, bus.data_ready);
        end
    endtask

    task automatic test_skp_idle();
        do_reset();
        enter_data();
        bus.data_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (bus.skp_pending !== 1'b0 || bus.sel !== 1'b1) begin
                failures++;
                $display("FAIL idle_count k=%0d: got pend=%b sel=%b, want 0 1", k, bus.skp_pending, bus.sel);
            end
        end
        tick();
        checks++;
        if (bus.skp_pending !== 1'b1 || bus.sel !== 1'b1 || bus.skp_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_pending: got pend=%b sel=%b start=%b, want 1 1 0",
                     bus.skp_pending, bus.sel, bus.skp_start);
        end
        tick();
        checks++;
        if (bus.skp_start !== 1'b1 || bus.sel !== 1'b0 || bus.data_ready !== 1'b0 ||
            bus.skp_pending !== 1'b0 || bus.skp_count !== 4'd1) begin
            failures++;
            $display("FAIL idle_skp_entry: got start=%b sel=%b rdy=%b pend=%b cnt=%0d, want 1 0 0 0 1",
                     bus.skp_start, bus.sel, bus.data_ready, bus.skp_pending, bus.skp_count);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.skp_start !== 1'b0 || bus.sel !== 1'b0) begin
                failures++;
                $display("FAIL idle_skp_hold k=%0d: got start=%b sel=%b, want 0 0", k, bus.skp_start, bus.sel);
            end
        end
        bus.os_done = 1'b1;
        tick();
        bus.os_done = 1'b0;
        checks++;
        if (bus.sel !== 1'b1 || bus.skp_count !== 4'd1 || bus.skp_pending !== 1'b0) begin
            failures++;
            $display("FAIL idle_skp_exit: got sel=%b cnt=%0d pend=%b, want 1 1 0",
                     bus.sel, bus.skp_count, bus.skp_pending);
        end
    endtask

    task automatic test_skp_deferred();
        int accepted_while_os;
        accepted_while_os = 0;
        do_reset();
        enter_data();
        for (int b = 1; b <= 12; b++) begin
            bus.data_req      = 1'b1;
            bus.data_boundary = (b == 12);
            bus.os_done       = (b == 3);
            checks++;
            if (bus.sel !== 1'b1 || bus.data_ready !== 1'b1 || bus.skp_pending !== (b >= 9)) begin
                failures++;
                $display("FAIL deferred_beat b=%0d: got sel=%b rdy=%b pend=%b, want 1 1 %b",
                         b, bus.sel, bus.data_ready, bus.skp_pending, (b >= 9));
            end
            tick();
        end
        bus.os_done       = 1'b0;
        bus.data_boundary = 1'b0;
        checks++;
        if (bus.skp_start !== 1'b1 || bus.sel !== 1'b0 || bus.data_ready !== 1'b0 || bus.skp_count !== 4'd1) begin
            failures++;
            $display("FAIL deferred_entry: got start=%b sel=%b rdy=%b cnt=%0d, want 1 0 0 1",
                     bus.skp_start, bus.sel, bus.data_ready, bus.skp_count);
        end
        for (int k = 0; k < 3; k++) begin
            if (bus.data_req && bus.data_ready) accepted_while_os++;
            tick();
        end
        checks++;
        if (accepted_while_os != 0 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL deferred_no_accept: got accepted=%0d sel=%b, want 0 0", accepted_while_os, bus.sel);
        end
        bus.os_done = 1'b1;
        tick();
        bus.os_done  = 1'b0;
        bus.data_req = 1'b0;
        checks++;
        if (bus.sel !== 1'b1 || bus.data_ready !== 1'b1) begin
            failures++;
            $display("FAIL deferred_exit: got sel=%b rdy=%b, want 1 1", bus.sel, bus.data_ready);
        end
    endtask

    task automatic test_link_drop_skp();
        do_reset();
        enter_data();
        bus.data_req = 1'b0;
        repeat (9) tick();
        checks++;
        if (bus.skp_start !== 1'b1 || bus.sel !== 1'b0 || bus.skp_count !== 4'd1) begin
            failures++;
            $display("FAIL drop_skp_entry: got start=%b sel=%b cnt=%0d, want 1 0 1",
                     bus.skp_start, bus.sel, bus.skp_count);
        end
        tick();
        bus.link_l0 = 1'b0;
        tick();
        tick();
        checks++;
        if (dut.state_q !== SKP || bus.sel !== 1'b0 || bus.skp_start !== 1'b0) begin
            failures++;
            $display("FAIL drop_skp_hold: got state=%0d sel=%b start=%b, want SKP 0 0",
                     dut.state_q, bus.sel, bus.skp_start);
        end
        bus.os_done = 1'b1;
        tick();
        bus.os_done = 1'b0;
        checks++;
        if (dut.state_q !== OS_MODE || bus.sel !== 1'b0 || bus.data_ready !== 1'b0 || bus.skp_count !== 4'd1) begin
            failures++;
            $display("FAIL drop_skp_exit: got state=%0d sel=%b rdy=%b cnt=%0d, want OS_MODE 0 0 1",
                     dut.state_q, bus.sel, bus.data_ready, bus.skp_count);
        end
        repeat (3) tick();
        checks++;
        if (bus.skp_count !== 4'd1 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL drop_skp_after: got cnt=%0d sel=%b, want 1 0", bus.skp_count, bus.sel);
        end
    endtask

    task automatic test_priority();
        do_reset();
        enter_data();
        bus.data_req      = 1'b1;
        bus.data_boundary = 1'b0;
        tick();
        bus.os_done = 1'b1;
        tick();
        bus.os_done = 1'b0;
        checks++;
        if (bus.sel !== 1'b1 || dut.state_q !== DATA) begin
            failures++;
            $display("FAIL os_done_in_data: got sel=%b state=%0d, want 1 DATA", bus.sel, dut.state_q);
        end
        repeat (7) tick();
        checks++;
        if (bus.skp_pending !== 1'b1 || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL prio_pending: got pend=%b sel=%b, want 1 1", bus.skp_pending, bus.sel);
        end
        bus.link_l0       = 1'b0;
        bus.data_boundary = 1'b1;
        tick();
        bus.data_req      = 1'b0;
        bus.data_boundary = 1'b0;
        checks++;
        if (dut.state_q !== OS_MODE || bus.skp_start !== 1'b0 || bus.sel !== 1'b0 ||
            bus.data_ready !== 1'b0 || bus.skp_count !== 4'd0) begin
            failures++;
            $display("FAIL prio_link_drop: got state=%0d start=%b sel=%b rdy=%b cnt=%0d, want OS_MODE 0 0 0 0",
                     dut.state_q, bus.skp_start, bus.sel, bus.data_ready, bus.skp_count);
        end
    endtask

    task automatic test_wrap_and_midreset();
        logic seen;
        do_reset();
        enter_data();
        bus.data_req = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (bus.skp_start === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || bus.skp_count !== 4'(n)) begin
                failures++;
                $display("FAIL wrap n=%0d: got seen=%b cnt=%0d, want 1 %0d", n, seen, bus.skp_count, 4'(n));
            end
            bus.os_done = 1'b1;
            tick();
            bus.os_done = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== OS_MODE ||
            {bus.sel, bus.data_ready, bus.skp_start, bus.skp_pending, bus.skp_count} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: got state=%0d sel=%b rdy=%b start=%b pend=%b cnt=%0d, want OS_MODE all 0",
                     dut.state_q, bus.sel, bus.data_ready, bus.skp_start, bus.skp_pending, bus.skp_count);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_skp_idle();
        test_skp_deferred();
        test_link_drop_skp();
        test_priority();
        test_wrap_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tx_mux_scheduler

`default_nettype wire

// File: doc/tx_mux_scheduler.md
Name: tx_mux_scheduler

Overview:
Sequences the Tx source multiplexer that selects between the ordered-set generator and the LPIF Tx data path (512-bit data, 64-bit datak/valid).
- Drives the mux select, back-pressures the LPIF data source and triggers SKP ordered sets on a fixed interval.
- Switches source only on packet boundaries (data side) or ordered-set boundaries (OS side), so no TLP/DLLP or ordered set is ever truncated.
- Sits between Tx LTSSM, LPIF Tx control/dataflow, OS generator and the mux.

Parameters:
- SKP_INTERVAL, 370, cycles in data mode between SKP insertions (must be >= 2).
- CNT_W, 16, width of SKP interval counter and SKP statistics counter.

Ports:
- clk  in  1  Tx clock.
- reset  in  1  synchronous, active-high reset.
- link_l0  in  1  Tx LTSSM: link in L0; data transfer permitted.
- data_req  in  1  LPIF: data beat pending.
- data_boundary  in  1  LPIF: current accepted beat ends a packet (valid only with data_req & data_ready).
- os_done  in  1  OS generator: last cycle of the current ordered set.
- sel  out  1  mux select (1 = data path, 0 = OS generator).
- data_ready  out  1  LPIF may advance a beat this cycle.
- skp_start  out  1  single-cycle pulse commanding the OS generator to emit one SKP OS.
- skp_pending  out  1  SKP interval elapsed, insertion not yet started.
- skp_count  out  CNT_W  number of SKP OS inserted (wraps).

Behaviour:
- Single clock domain. Reset is synchronous, active-high, on clk. All outputs are registered.
- Reset values: sel=0, data_ready=0, skp_start=0, skp_pending=0, skp_count=0, state=OS_MODE, interval counter=0.
- Boundary condition each cycle: bnd = (data_req & data_ready & data_boundary) | ~data_req. An idle data source is always at a boundary.
- States:
  - OS_MODE: sel=0, data_ready=0; OS generator streams training sets. Go to DATA when link_l0 & os_done in the same cycle.
  - DATA: sel=1, data_ready=1; interval counter increments each cycle.
    - At bnd with ~link_l0: go to OS_MODE.
    - Else at bnd with skp_pending: go to SKP.
    - Otherwise stay.
  - SKP: sel=0, data_ready=0. On entry cycle, skp_start=1 for exactly one cycle; skp_pending clears, skp_count+1, interval counter cleared. Wait for os_done.
    - On os_done with link_l0: go to DATA.
    - On os_done with ~link_l0: go to OS_MODE.
    - A SKP in progress always completes.
- Transition latency: the state change and the new sel/data_ready take effect on the clock edge after the deciding cycle. data_ready drops in the same edge that sel drops, so no beat is accepted while sel=0.
- Interval counter: counts only in DATA. When it reaches SKP_INTERVAL-1, skp_pending sets on the next edge and the counter saturates (no wrap). Counter is cleared in OS_MODE and on SKP entry.
- Simultaneous events:
  - link_l0 deassertion has priority over a pending SKP at a boundary.
  - skp_pending asserting in the same cycle as bnd is seen the following cycle; SKP is taken at the next bnd.
- os_done in DATA is ignored. data_boundary without data_req & data_ready is ignored.
- skp_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: immediate return to reset values at the next edge, regardless of state. sel=0 forces the OS path.

Decomposition:
- Shared package pcie_tx_pkg:
  - state enum {OS_MODE, DATA, SKP}
  - SEL_DATA=1, SEL_OS=0 constants
  - default SKP_INTERVAL value
- One natural sub-module: skp_interval_timer, holding the saturating interval counter and generating skp_pending set/clear.
- FSM and output registers stay in the top.

Test Plan:
- Reset: hold reset 3 cycles with link_l0=1 and os_done=1 -> sel=0, data_ready=0, skp_count=0 throughout; DATA entered only on the first edge after reset releases with os_done=1.
- Link up: link_l0=1, os_done pulse at cycle 5 -> sel=1 and data_ready=1 from cycle 6.
- SKP on idle source: SKP_INTERVAL=8, data_req=0 -> skp_pending at 8 cycles into DATA, skp_start pulse next cycle, sel=0; os_done 4 cycles later -> sel=1, skp_count=1.
- SKP deferred by packet: SKP_INTERVAL=8, 12-beat packet, data_boundary on beat 12 -> sel stays 1 until after beat 12; skp_start fires on the following edge; no beat accepted while sel=0.
- Link drop during SKP: link_l0 falls 1 cycle after skp_start -> remain in SKP until os_done, then OS_MODE with sel=0 and data_ready=0; skp_count incremented once.
- Priority and wrap: link drop and skp_pending both at a boundary -> OS_MODE, no skp_start. With CNT_W=4, 16 SKPs -> skp_count wraps to 0.
